// File: rtl/rename_pkg.sv
// Shared rename/retire definitions: register-file sizing and the physical
// register index type. Imported by the rename stage and by preg_reclaim.
package rename_pkg;

  localparam int unsigned NUM_PREG = 64;
  localparam int unsigned NUM_AREG = 32;
  localparam int unsigned PREG_W   = 6;
  localparam int unsigned FL_DEPTH = NUM_PREG - NUM_AREG;

  typedef logic [PREG_W-1:0] preg_t;

  // Physical register 0 is hard-wired to x0: never allocated, never freed.
  localparam preg_t PREG_ZERO = '0;

endpackage

// File: rtl/preg_fifo.sv
// Generic circular FIFO whose slots are preloaded on reset with the
// consecutive values PRELOAD_BASE, PRELOAD_BASE+1, ... and that starts full.
// DEPTH must be a power of two so the pointers wrap naturally.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_pop         remove head entry (ignored when empty)
//   i_push        append i_push_data at tail (ignored when full)
//   o_head_data   entry at head, combinational from the head pointer
//   o_count       number of valid entries (0..DEPTH)
//   o_empty       no valid entries
//   o_full        DEPTH valid entries
module preg_fifo #(
  parameter  int unsigned DEPTH        = 32,
  parameter  int unsigned W            = 6,
  parameter  int unsigned PRELOAD_BASE = 32,
  localparam int unsigned PTR_W        = $clog2(DEPTH),
  localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pop,
  input  logic             i_push,
  input  logic [W-1:0]     i_push_data,
  output logic [W-1:0]     o_head_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_head];

  assign w_pop  = i_pop  & ~o_empty;
  assign w_push = i_push & ~o_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= W'(PRELOAD_BASE + i);
      end
    end else if (w_push) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_W'(DEPTH);
    end else begin
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push) r_tail <= r_tail + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/preg_reclaim.sv
// Retire-side physical register management: owns the free list (preg_fifo),
// the committed RAT and the per-preg busy bits. Rename pops destination
// pregs; ROB commit returns superseded pregs and updates the committed RAT.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   alloc_req                       rename takes one preg this cycle
//   alloc_valid / alloc_preg        free-list head is valid / head value
//   fl_empty, free_count            free-list status for rename stall
//   retire_valid / retire_ready     commit handshake from ROB head
//   retire_has_dest, retire_arch_dr committing instruction's destination
//   retire_new_preg, retire_old_preg new mapping / superseded preg
//   crat_rd_addr / crat_rd_data     committed-RAT read port (no forwarding)
//   retired_cnt                     accepted retires, wraps at 2^16
//   err_double_free                 sticky: released preg was already free
module preg_reclaim
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PREG_W-1:0] alloc_preg,
  output logic              fl_empty,
  output logic [PREG_W-1:0] free_count,
  input  logic              retire_valid,
  output logic              retire_ready,
  input  logic              retire_has_dest,
  input  logic [4:0]        retire_arch_dr,
  input  logic [PREG_W-1:0] retire_new_preg,
  input  logic [PREG_W-1:0] retire_old_preg,
  input  logic [4:0]        crat_rd_addr,
  output logic [PREG_W-1:0] crat_rd_data,
  output logic [15:0]       retired_cnt,
  output logic              err_double_free
);

  preg_t               r_crat [NUM_AREG];
  logic [NUM_PREG-1:0] r_busy;
  logic [15:0]         r_retired_cnt;
  logic                r_err_double_free;

  logic  w_empty;
  logic  w_full;
  logic  w_pop;
  logic  w_ret_acc;
  logic  w_rat_wr;
  logic  w_release;
  logic  w_old_busy;
  logic  w_push;
  logic  w_dbl_free;
  preg_t w_head;

  assign w_pop      = alloc_req & ~w_empty;
  assign w_ret_acc  = retire_valid & retire_ready;
  assign w_rat_wr   = w_ret_acc & retire_has_dest & (retire_arch_dr != '0);
  assign w_release  = w_rat_wr & (retire_old_preg != PREG_ZERO);
  assign w_old_busy = r_busy[retire_old_preg];
  assign w_push     = w_release & w_old_busy;
  assign w_dbl_free = w_release & ~w_old_busy;

  preg_fifo #(
    .DEPTH       (FL_DEPTH),
    .W           (PREG_W),
    .PRELOAD_BASE(NUM_AREG)
  ) u_free_list (
    .clk        (clk),
    .rst        (rst),
    .i_pop      (w_pop),
    .i_push     (w_push),
    .i_push_data(retire_old_preg),
    .o_head_data(w_head),
    .o_count    (free_count),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  assign alloc_valid     = ~w_empty;
  assign alloc_preg      = w_head;
  assign fl_empty        = w_empty;
  // Gated by the registered count only; a same-cycle pop does not open it.
  assign retire_ready    = ~rst & ~w_full;
  assign crat_rd_data    = r_crat[crat_rd_addr];
  assign retired_cnt     = r_retired_cnt;
  assign err_double_free = r_err_double_free;

  // Popped preg is free (busy=0) while a pushed preg is busy, so the set and
  // clear below never target the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PREG; i++) begin
        r_busy[i] <= (i < NUM_AREG);
      end
    end else begin
      if (w_pop)  r_busy[w_head]          <= 1'b1;
      if (w_push) r_busy[retire_old_preg] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_AREG; i++) begin
        r_crat[i] <= PREG_W'(i);
      end
    end else if (w_rat_wr) begin
      r_crat[retire_arch_dr] <= retire_new_preg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired_cnt     <= '0;
      r_err_double_free <= 1'b0;
    end else begin
      if (w_ret_acc)  r_retired_cnt     <= r_retired_cnt + 16'd1;
      if (w_dbl_free) r_err_double_free <= 1'b1;
    end
  end

endmodule

// File: tb/tb_preg_reclaim.sv
module tb_preg_reclaim;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_preg;
  logic       fl_empty;
  logic [5:0] free_count;
  logic       retire_valid;
  logic       retire_ready;
  logic       retire_has_dest;
  logic [4:0] retire_arch_dr;
  logic [5:0] retire_new_preg;
  logic [5:0] retire_old_preg;
  logic [4:0] crat_rd_addr;
  logic [5:0] crat_rd_data;
  logic [15:0] retired_cnt;
  logic       err_double_free;

  preg_reclaim dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req      (alloc_req),
    .alloc_valid    (alloc_valid),
    .alloc_preg     (alloc_preg),
    .fl_empty       (fl_empty),
    .free_count     (free_count),
    .retire_valid   (retire_valid),
    .retire_ready   (retire_ready),
    .retire_has_dest(retire_has_dest),
    .retire_arch_dr (retire_arch_dr),
    .retire_new_preg(retire_new_preg),
    .retire_old_preg(retire_old_preg),
    .crat_rd_addr   (crat_rd_addr),
    .crat_rd_data   (crat_rd_data),
    .retired_cnt    (retired_cnt),
    .err_double_free(err_double_free)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: free list as a queue, busy flags, committed map.
  int          fl[$];
  bit          mbusy[64];
  int          mcrat[32];
  int unsigned mret;
  bit          merr;

  typedef struct {
    bit req; bit rv; bit hd; int arch; int newp; int old; int rd;
    int e_valid; int e_preg; int e_cnt; int e_ready; int e_crat; int e_ret; int e_err;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
    for (int i = 0; i < 64; i++) mbusy[i] = (i < 32);
    for (int i = 0; i < 32; i++) mcrat[i] = i;
    mret = 0;
    merr = 0;
  endtask

  task automatic set_in(input bit req, input bit rv, input bit hd, input int arch,
                        input int newp, input int old, input int rd);
    alloc_req       = req;
    retire_valid    = rv;
    retire_has_dest = hd;
    retire_arch_dr  = 5'(arch);
    retire_new_preg = 6'(newp);
    retire_old_preg = 6'(old);
    crat_rd_addr    = 5'(rd);
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_adv();
    bit ready;
    bit ob;
    int old;
    int p;
    old   = int'(retire_old_preg);
    ready = (fl.size() < 32);
    ob    = mbusy[old];
    if (alloc_req && fl.size() > 0) begin
      p = fl.pop_front();
      mbusy[p] = 1;
    end
    if (retire_valid && ready) begin
      mret = (mret + 1) % 65536;
      if (retire_has_dest && retire_arch_dr != 0) begin
        mcrat[retire_arch_dr] = int'(retire_new_preg);
        if (old != 0) begin
          if (!ob) merr = 1;
          else begin
            fl.push_back(old);
            mbusy[old] = 0;
          end
        end
      end
    end
  endtask

  task automatic model_cmp();
    chk("alloc_valid", int'(alloc_valid), int'(fl.size() > 0));
    if (fl.size() > 0) chk("alloc_preg", int'(alloc_preg), fl[0]);
    chk("fl_empty", int'(fl_empty), int'(fl.size() == 0));
    chk("free_count", int'(free_count), fl.size());
    chk("retire_ready", int'(retire_ready), int'(fl.size() < 32));
    chk("retired_cnt", int'(retired_cnt), int'(mret));
    chk("err_double_free", int'(err_double_free), int'(merr));
    chk("crat_rd_data", int'(crat_rd_data), mcrat[crat_rd_addr]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One modelled cycle: compare pre-edge outputs, then advance DUT and model.
  task automatic cycle_model();
    @(negedge clk);
    model_cmp();
    model_adv();
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".alloc_valid"}, int'(alloc_valid), 1);
    chk({tag, ".alloc_preg"}, int'(alloc_preg), 32);
    chk({tag, ".fl_empty"}, int'(fl_empty), 0);
    chk({tag, ".free_count"}, int'(free_count), 32);
    chk({tag, ".retire_ready"}, int'(retire_ready), 0);
    chk({tag, ".retired_cnt"}, int'(retired_cnt), 0);
    chk({tag, ".err"}, int'(err_double_free), 0);
    chk({tag, ".crat5"}, int'(crat_rd_data), 5);
  endtask

  initial begin
    //          req rv hd arch new old rd | valid preg cnt rdy crat ret err
    tbl[0]  = '{1, 0, 0, 0, 0,  0,  5,   1, 32, 32, 0, 5,  0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0,  0,  5,   1, 33, 31, 1, 5,  0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0,  0,  5,   1, 34, 30, 1, 5,  0, 0};
    tbl[3]  = '{0, 1, 1, 5, 32, 5,  5,   1, 35, 29, 1, 5,  0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0,  0,  5,   1, 35, 30, 1, 32, 1, 0};
    tbl[5]  = '{0, 1, 1, 0, 33, 33, 0,   1, 35, 30, 1, 0,  1, 0};
    tbl[6]  = '{0, 1, 0, 6, 34, 34, 6,   1, 35, 30, 1, 6,  2, 0};
    tbl[7]  = '{0, 1, 1, 9, 34, 40, 9,   1, 35, 30, 1, 9,  3, 0};
    tbl[8]  = '{0, 0, 0, 0, 0,  0,  9,   1, 35, 30, 1, 34, 4, 1};
    tbl[9]  = '{1, 0, 0, 0, 0,  0,  5,   1, 35, 30, 1, 32, 4, 1};
    tbl[10] = '{0, 0, 0, 0, 0,  0,  5,   1, 36, 29, 1, 32, 4, 1};

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 5);
    model_reset();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Directed table: allocation order, retire variants, double free.
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].req, tbl[i].rv, tbl[i].hd, tbl[i].arch, tbl[i].newp, tbl[i].old, tbl[i].rd);
      @(negedge clk);
      chk($sformatf("tbl%0d.alloc_valid", i), int'(alloc_valid), tbl[i].e_valid);
      chk($sformatf("tbl%0d.alloc_preg", i), int'(alloc_preg), tbl[i].e_preg);
      chk($sformatf("tbl%0d.free_count", i), int'(free_count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d.retire_ready", i), int'(retire_ready), tbl[i].e_ready);
      chk($sformatf("tbl%0d.crat", i), int'(crat_rd_data), tbl[i].e_crat);
      chk($sformatf("tbl%0d.retired_cnt", i), int'(retired_cnt), tbl[i].e_ret);
      chk($sformatf("tbl%0d.err", i), int'(err_double_free), tbl[i].e_err);
      model_adv();
      tick();
    end

    // Drain the free list (36..63 then the returned preg 5).
    for (int k = 0; k < 29; k++) begin
      set_in(1, 0, 0, 0, 0, 0, k % 32);
      cycle_model();
    end
    chk("drain.last_was_5", int'(mbusy[5]), 1);

    // alloc_req while empty: ignored.
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("empty.alloc_valid", int'(alloc_valid), 0);
    chk("empty.fl_empty", int'(fl_empty), 1);
    chk("empty.free_count", int'(free_count), 0);
    model_adv();
    tick();
    chk("empty_hold.free_count", int'(free_count), 0);
    chk("empty_hold.fl_empty", int'(fl_empty), 1);

    // Empty list, same-cycle retire of preg 7 and alloc_req: no bypass.
    set_in(1, 1, 1, 7, 40, 7, 7);
    @(negedge clk);
    chk("nobypass.alloc_valid", int'(alloc_valid), 0);
    chk("nobypass.retire_ready", int'(retire_ready), 1);
    model_adv();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 7);
    @(negedge clk);
    chk("after_push.alloc_valid", int'(alloc_valid), 1);
    chk("after_push.alloc_preg", int'(alloc_preg), 7);
    chk("after_push.free_count", int'(free_count), 1);
    chk("after_push.crat7", int'(crat_rd_data), 40);
    model_adv();
    tick();

    // Return pregs 8..16 to reach count=10, then reset mid-cycle.
    for (int k = 8; k <= 16; k++) begin
      set_in(0, 1, 1, k, 41 + k, k, k);
      cycle_model();
    end
    set_in(0, 0, 0, 0, 0, 0, 5);
    @(negedge clk);
    chk("pre_rst.free_count", int'(free_count), 10);
    chk("pre_rst.crat5", int'(crat_rd_data), 32);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    tick();
    chk_reset_outputs("midrst_held");
    rst = 1'b0;
    model_reset();

    // Randomised traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      int old;
      old = $urandom_range(0, 63);
      for (int t = 0; t < 4 && !mbusy[old]; t++) old = $urandom_range(1, 63);
      set_in(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 99) < 60),
             bit'($urandom_range(0, 99) < 85), $urandom_range(0, 31),
             $urandom_range(1, 63), old, $urandom_range(0, 31));
      cycle_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
